// File: rtl/dac_spi_receiver_pkg.sv
// Shared types and constants for the DAC serial-link responder.
package dac_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DEFAULT_WORD_BITS = 16;

    // Levels the link rests at when no driver is active
    localparam logic SCK_IDLE  = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic SDI_IDLE  = 1'b0;
    localparam logic LDAC_IDLE = 1'b1;

endpackage

// File: rtl/dac_spi_receiver_if.sv
// Link pins plus the received-word stream and status of the DAC responder.
interface dac_spi_receiver_if
    import dac_spi_pkg::*;
#(
    parameter int WORD_BITS = DEFAULT_WORD_BITS
);

    logic                 DAC_SCK;
    logic                 DAC_CS;
    logic                 DAC_SDI;
    logic                 DAC_LDAC;
    logic [WORD_BITS-1:0] word_bits;
    logic                 word_valid;
    logic                 word_ready;
    logic [WORD_BITS-1:0] dac_value;
    logic                 dac_update;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output DAC_SCK, DAC_CS, DAC_SDI, DAC_LDAC, word_ready,
        input  word_bits, word_valid, dac_value, dac_update, frame_err, overrun, busy
    );

    modport slave (
        input  DAC_SCK, DAC_CS, DAC_SDI, DAC_LDAC, word_ready,
        output word_bits, word_valid, dac_value, dac_update, frame_err, overrun, busy
    );

endinterface

// File: rtl/dac_spi_receiver_sync_edge.sv
// Multi-stage synchroniser with rise/fall detection; reset loads the idle level
// into every stage so releasing reset never looks like an edge.
module sync_edge
    import dac_spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stages <= {SYNC_STAGES{IDLE_LEVEL}};
            prev   <= IDLE_LEVEL;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], async_in};
            prev   <= stages[SYNC_STAGES-1];
        end
    end

    assign level = stages[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/dac_spi_receiver.sv
// Oversampling responder for the four-wire DAC link: deserialises MSB-first
// frames into an input register and models the LDAC-loaded output register.
module dac_spi_receiver
    import dac_spi_pkg::*;
#(
    parameter int WORD_BITS   = DEFAULT_WORD_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    dac_spi_receiver_if.slave  link
);

    localparam int                CNT_W     = $clog2(WORD_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(WORD_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORD_BITS);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic sdi_level, sdi_rise, sdi_fall;
    logic ldac_level, ldac_rise, ldac_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(SCK_IDLE)) u_sck (
        .clock(clock), .reset_n(reset_n), .async_in(link.DAC_SCK),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(CS_IDLE)) u_cs (
        .clock(clock), .reset_n(reset_n), .async_in(link.DAC_CS),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(SDI_IDLE)) u_sdi (
        .clock(clock), .reset_n(reset_n), .async_in(link.DAC_SDI),
        .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(LDAC_IDLE)) u_ldac (
        .clock(clock), .reset_n(reset_n), .async_in(link.DAC_LDAC),
        .level(ldac_level), .rise(ldac_rise), .fall(ldac_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sck_level, sck_fall, sdi_rise, sdi_fall, ldac_level, ldac_rise};

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [WORD_BITS-1:0]   input_reg;
    logic                   frame_load;
    logic                   frame_bad;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

    // Counter saturates one past a full word so long frames stay distinguishable
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        frame_load = 1'b0;
        frame_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    count_d = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (sck_rise && !cs_level) begin
                    shift_d = {shift_q[WORD_BITS-2:0], sdi_level};
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (cs_rise) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d    = IDLE;
                frame_load = (count_q == CNT_FULL);
                frame_bad  = (count_q != '0) && (count_q != CNT_FULL);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            input_reg       <= '0;
            link.word_bits  <= '0;
            link.word_valid <= 1'b0;
            link.overrun    <= 1'b0;
            link.frame_err  <= 1'b0;
            link.dac_value  <= '0;
            link.dac_update <= 1'b0;
        end else begin
            link.overrun    <= 1'b0;
            link.frame_err  <= frame_bad;
            link.dac_update <= ldac_fall;
            if (frame_load) begin
                input_reg       <= shift_q;
                link.word_bits  <= shift_q;
                link.word_valid <= 1'b1;
                link.overrun    <= link.word_valid && !link.word_ready;
            end else if (link.word_valid && link.word_ready) begin
                link.word_valid <= 1'b0;
            end
            // A word completing in the same cycle as LDAC passes straight through
            if (ldac_fall) begin
                link.dac_value <= frame_load ? shift_q : input_reg;
            end
        end
    end

    assign link.busy = (state_q == SHIFT);

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Randomised bench for dac_spi_receiver against a frame-level reference model.
module tb_dac_spi_receiver;
    import dac_spi_pkg::*;

    localparam int WB = 16;
    localparam int SS = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    dac_spi_receiver_if #(.WORD_BITS(WB)) link ();

    dac_spi_receiver #(.WORD_BITS(WB), .SYNC_STAGES(SS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .link    (link)
    );

    int vectors     = 0;
    int miscompares = 0;

    int valid_cycles  = 0;
    int err_pulses    = 0;
    int overrun_count = 0;
    int update_pulses = 0;
    logic [WB-1:0] accepted_q[$];

    logic [WB-1:0] exp_input = '0;
    logic [WB-1:0] exp_dac   = '0;
    logic [WB-1:0] exp_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Observe the stream side once per cycle, away from the active edge
    always @(negedge clock) begin
        if (reset_n) begin
            if (link.word_valid) valid_cycles++;
            if (link.word_valid && link.word_ready) accepted_q.push_back(link.word_bits);
            if (link.frame_err) err_pulses++;
            if (link.overrun) overrun_count++;
            if (link.dac_update) update_pulses++;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic frameBegin();
        link.DAC_CS = 1'b0;
        idle(4);
    endtask

    task automatic sendBits(input logic [31:0] v, input int nbits, input int first, input int last);
        for (int i = first; i < last; i++) begin
            link.DAC_SDI = v[nbits-1-i];
            idle(4);
            link.DAC_SCK = 1'b1;
            idle(4);
            link.DAC_SCK = 1'b0;
        end
    endtask

    task automatic frameEnd();
        idle(4);
        link.DAC_CS  = 1'b1;
        link.DAC_SDI = 1'b0;
        idle(10);
    endtask

    // Reference: full frames become the new input word, empty ones vanish, others are errors
    task automatic modelFrame(input logic [31:0] v, input int nbits);
        if (nbits == WB) begin
            exp_input = v[WB-1:0];
            exp_q.push_back(v[WB-1:0]);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] v, input int nbits);
        frameBegin();
        sendBits(v, nbits, 0, nbits);
        frameEnd();
        modelFrame(v, nbits);
    endtask

    task automatic pulseLdac();
        link.DAC_LDAC = 1'b0;
        idle(6);
        link.DAC_LDAC = 1'b1;
        idle(6);
        exp_dac = exp_input;
    endtask

    task automatic checkQueues(input string tag);
        checkOutput({tag, "_count"}, 32'(accepted_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < accepted_q.size() && i < exp_q.size(); i++)
            checkOutput({tag, "_word"}, 32'(accepted_q[i]), 32'(exp_q[i]));
        accepted_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int base_v, base_e, base_o, base_u, rand_errs, nbits;
        logic [31:0] v;

        link.DAC_SCK    = SCK_IDLE;
        link.DAC_CS     = CS_IDLE;
        link.DAC_SDI    = SDI_IDLE;
        link.DAC_LDAC   = LDAC_IDLE;
        link.word_ready = 1'b1;
        idle(5);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checkOutput("reset_regs", {link.word_bits, link.dac_value}, 32'h0);
            checkOutput("reset_flags", {27'h0, link.word_valid, link.dac_update, link.frame_err,
                                        link.overrun, link.busy}, 32'h0);
        end

        base_v = valid_cycles;
        applyStimulus(32'hA55A, 16);
        checkOutput("a55a_word", 32'(link.word_bits), 32'hA55A);
        checkOutput("a55a_valid_cycles", 32'(valid_cycles - base_v), 32'd1);
        checkQueues("a55a");
        base_u = update_pulses;
        pulseLdac();
        checkOutput("a55a_dac", 32'(link.dac_value), 32'(exp_dac));
        checkOutput("a55a_updates", 32'(update_pulses - base_u), 32'd1);

        base_e = err_pulses;
        base_v = valid_cycles;
        applyStimulus(32'h7ABC, 15);
        applyStimulus(32'h1F0F0, 17);
        checkOutput("badlen_errs", 32'(err_pulses - base_e), 32'd2);
        checkOutput("badlen_valid", 32'(valid_cycles - base_v), 32'd0);
        pulseLdac();
        checkOutput("badlen_dac", 32'(link.dac_value), 32'hA55A);
        checkQueues("badlen");

        link.word_ready = 1'b0;
        base_o = overrun_count;
        applyStimulus(32'h1234, 16);
        applyStimulus(32'hBEEF, 16);
        checkOutput("bp_overrun", 32'(overrun_count - base_o), 32'd1);
        checkOutput("bp_word", 32'(link.word_bits), 32'hBEEF);
        idle(20);
        checkOutput("bp_hold_valid", 32'(link.word_valid), 32'd1);
        link.word_ready = 1'b1;
        idle(3);
        checkOutput("bp_drop_valid", 32'(link.word_valid), 32'd0);
        void'(exp_q.pop_front());
        checkQueues("bp");

        applyStimulus(32'h00FF, 16);
        pulseLdac();
        checkOutput("mid_first_dac", 32'(link.dac_value), 32'h00FF);
        frameBegin();
        sendBits(32'hFF00, 16, 0, 8);
        checkOutput("mid_busy", 32'(link.busy), 32'd1);
        base_u = update_pulses;
        pulseLdac();
        checkOutput("mid_ldac_dac", 32'(link.dac_value), 32'(exp_dac));
        checkOutput("mid_ldac_updates", 32'(update_pulses - base_u), 32'd1);
        sendBits(32'hFF00, 16, 8, 16);
        frameEnd();
        modelFrame(32'hFF00, 16);
        pulseLdac();
        checkOutput("mid_second_dac", 32'(link.dac_value), 32'hFF00);
        checkQueues("mid");

        base_e = err_pulses;
        frameBegin();
        sendBits(32'h3C3C, 16, 0, 10);
        reset_n = 1'b0;
        idle(3);
        link.DAC_CS  = 1'b1;
        link.DAC_SDI = 1'b0;
        idle(2);
        reset_n = 1'b1;
        exp_input = '0;
        exp_dac   = '0;
        idle(5);
        checkOutput("rst_dac_cleared", 32'(link.dac_value), 32'(exp_dac));
        checkOutput("rst_busy", 32'(link.busy), 32'd0);
        applyStimulus(32'h0F0F, 16);
        checkOutput("rst_no_err", 32'(err_pulses - base_e), 32'd0);
        checkQueues("rst");

        base_e = err_pulses;
        base_o = overrun_count;
        rand_errs = 0;
        for (int i = 0; i < 24; i++) begin
            v = $urandom;
            nbits = ($urandom_range(0, 3) != 0) ? WB : int'($urandom_range(0, 18));
            if (nbits != 0 && nbits != WB) rand_errs++;
            applyStimulus(v, nbits);
            if ($urandom_range(0, 1) == 1) begin
                pulseLdac();
                checkOutput("rand_dac", 32'(link.dac_value), 32'(exp_dac));
            end
        end
        checkOutput("rand_errs", 32'(err_pulses - base_e), 32'(rand_errs));
        checkOutput("rand_overrun", 32'(overrun_count - base_o), 32'd0);
        checkQueues("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dac_spi_receiver.md
# dac_spi_receiver

Serial-DAC responder: the far end of the four-wire DAC write link (SCK, CS, SDI, LDAC) driven by the team's DAC channels. The block oversamples the link on the system clock and deserialises MSB-first frames. It models the DAC's input register and its LDAC-loaded output register. It is used for on-board loopback self-test of every DAC channel and as the bench responder for DAC driver verification.

## Interface
- WORD_BITS, 16: bits per frame and width of both modelled registers
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (≥2)

- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- DAC_SCK  in  1  serial clock from the DAC driver, asynchronous to clock
- DAC_CS  in  1  chip select, active low, asynchronous
- DAC_SDI  in  1  serial data, MSB first, sampled on SCK rising edge
- DAC_LDAC  in  1  load strobe, active low, falling edge acts
- word_bits  out  WORD_BITS  last complete frame (stream payload)
- word_valid  out  1  payload valid, held until accepted
- word_ready  in  1  downstream accepts when valid && ready
- dac_value  out  WORD_BITS  modelled DAC output register
- dac_update  out  1  one-cycle pulse when dac_value loads
- frame_err  out  1  one-cycle pulse on a malformed frame
- overrun  out  1  one-cycle pulse when a pending word is overwritten
- busy  out  1  high while a frame is in progress (state SHIFT)

## Operation
- Each of SCK, CS, SDI, LDAC passes through a SYNC_STAGES synchroniser. Reset preloads the synchronisers to idle levels: SCK=0, CS=1, SDI=0, LDAC=1. No edge is ever detected as a result of reset.
- FSM states:
  - IDLE: entered on reset. Synchronised CS falling edge → SHIFT; clears bit counter and shift register.
  - SHIFT: each SCK rising edge shifts SDI into the LSB and increments the counter. The counter saturates at WORD_BITS+1. CS rising edge → DONE.
  - DONE: single cycle, always → IDLE.
- Frame check in DONE:
  - count == WORD_BITS: the shift register loads the input register and word_bits. word_valid is set.
  - count == 0: frame ignored silently.
  - any other count: frame_err pulses; the input register and stream are unchanged.
- Overrun: if word_valid is already set and not being accepted in the same cycle, the new word overwrites word_bits and overrun pulses.
- LDAC falling edge: dac_value ← input register; dac_update pulses. This applies in any FSM state, including mid-frame.
- SCK edges while CS is high are ignored. A CS falling edge while in SHIFT cannot occur (CS is already low).

## Timing
- Reset values:
  - word_bits = 0, word_valid = 0, dac_value = 0
  - dac_update = 0, frame_err = 0, overrun = 0, busy = 0
  - state = IDLE
- Pin-to-edge latency: SYNC_STAGES + 1 clock cycles.
- Link constraint: SCK high and low times each ≥ 3 clock periods. CS setup/hold to SCK ≥ 3 clock periods. Violations are not detected.
- CS rising edge to word_valid: DONE is one cycle after the detected edge. word_valid is registered high at the end of DONE.
- Handshake:
  - word_valid, once high, stays high until the cycle with word_ready=1.
  - It drops the following cycle unless a new word loads in that same cycle, in which case it stays high with the new word and no overrun.
- Simultaneous events: if an LDAC falling edge is detected in the DONE cycle of a valid frame, dac_value takes the new word (pass-through). dac_update fires in that cycle's next edge.
- reset_n asserted mid-frame clears everything asynchronously. The partial frame is discarded with no frame_err.

## Structure
- Package dac_spi_pkg holds:
  - the FSM state enum (IDLE, SHIFT, DONE)
  - the default WORD_BITS constant
  - the idle-level constants for the four link pins
- Sub-module sync_edge: parameterised synchroniser plus rise/fall detect with a reset idle level. It is instantiated four times.

## Test plan
- Reset idle: hold reset_n low, then release. All outputs stay 0 for 20 cycles with the link idle.
- Frame 0xA55A: send a 16-bit frame with the driver at clock/8, word_ready=1. word_bits=0xA55A and word_valid pulses for 1 cycle. Then pulse LDAC: dac_value=0xA55A and one dac_update.
- Short and long frames: send 15 bits, then 17 bits. frame_err pulses twice; word_valid never rises; dac_value is unchanged.
- Backpressure: word_ready=0, send 0x1234 then 0xBEEF. A single overrun pulse occurs, word_bits=0xBEEF, and word_valid stays high until ready.
- LDAC mid-frame: latch 0x00FF, start frame 0xFF00, pulse LDAC after 8 bits. dac_value=0x00FF. After a second LDAC, dac_value=0xFF00.
- Reset mid-frame: assert reset_n after 10 bits, then send a full 0x0F0F frame. Only 0x0F0F is reported, with no frame_err.
